// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and constants for the two-requester APB command arbiter.
package apb_req_arbiter_pkg;

    localparam int SLV_ADDR_WIDTH      = 2;
    localparam int ADDR_WIDTH          = 8;
    localparam int DATA_WIDTH          = 16;
    localparam int ARB_NUM_REQ         = 2;
    localparam int ARB_TIMEOUT_DEFAULT = 64;

    // Arbiter sequencing: one command in flight at a time.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    // Command as presented to the APB master front end.
    typedef struct packed {
        logic                      wr;
        logic [SLV_ADDR_WIDTH-1:0] slv_addr;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [DATA_WIDTH-1:0]     wdata;
    } apb_cmd_t;

    // One-hot vector for a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Two-requester round-robin picker: combinational winner select plus the
// priority pointer, which moves past the requester just served.
module apb_rr_pick (
    input  logic       i_pclk,
    input  logic       i_presetn,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    input  logic       i_last_owner,
    output logic       o_valid,
    output logic       o_winner
);

    logic r_ptr;

    // Pointer register: after a completion, the other requester gets priority.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~i_last_owner;
        end
    end

    // Winner: requester at the pointer if it is asking, otherwise the other one.
    always_comb begin
        o_valid  = |i_req;
        o_winner = i_req[r_ptr] ? r_ptr : ~r_ptr;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master command interface between two requesters.
//
// Requester handshake: a requester raises req_i[n] (a level) with its
// command fields stable and keeps them until ack_o[n] pulses for one cycle;
// the command is latched at grant, so dropping req_i afterwards does not
// cancel it. rdata_o/err_o are valid with ack_o and hold until the next ack.
// Master handshake: newd_o is a one-cycle strobe with the command fields,
// which stay stable until mst_done_i (only honoured while waiting) or the
// watchdog ends the transfer.
module apb_req_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = ARB_NUM_REQ,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
    input  logic                              pclk,
    input  logic                              presetn,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0]                req_wr_i,
    input  logic [NUM_REQ*SLV_ADDR_WIDTH-1:0] req_slv_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                ack_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              err_o,
    output logic                              newd_o,
    output logic                              wr_o,
    output logic [SLV_ADDR_WIDTH-1:0]         slv_addr_o,
    output logic [ADDR_WIDTH-1:0]             addr_o,
    output logic [DATA_WIDTH-1:0]             wdata_o,
    input  logic                              mst_done_i,
    input  logic [DATA_WIDTH-1:0]             mst_rdata_i,
    input  logic                              mst_slverr_i,
    output arb_state_t                        dbg_state_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t            r_state;
    arb_state_t            w_next;
    apb_cmd_t              r_cmd;
    apb_cmd_t              w_sel_cmd;
    logic                  r_owner;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  w_valid;
    logic                  w_winner;
    logic                  w_grant;
    logic                  w_timeout;

    apb_rr_pick u_pick (
        .i_pclk       (pclk),
        .i_presetn    (presetn),
        .i_req        (req_i),
        .i_advance    (r_state == ARB_RESP),
        .i_last_owner (r_owner),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    // Grant happens only from IDLE; watchdog fires on the last allowed wait cycle.
    always_comb begin
        w_grant   = (r_state == ARB_IDLE) && w_valid;
        w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end

    // Select the winning requester's command fields.
    always_comb begin
        w_sel_cmd.wr       = w_winner ? req_wr_i[1] : req_wr_i[0];
        w_sel_cmd.slv_addr = w_winner ? req_slv_i[SLV_ADDR_WIDTH +: SLV_ADDR_WIDTH]
                                      : req_slv_i[0 +: SLV_ADDR_WIDTH];
        w_sel_cmd.addr     = w_winner ? req_addr_i[ADDR_WIDTH +: ADDR_WIDTH]
                                      : req_addr_i[0 +: ADDR_WIDTH];
        w_sel_cmd.wdata    = w_winner ? req_wdata_i[DATA_WIDTH +: DATA_WIDTH]
                                      : req_wdata_i[0 +: DATA_WIDTH];
    end

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: done on the terminal count cycle still counts as done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:  if (w_valid) w_next = ARB_ISSUE;
            ARB_ISSUE: w_next = ARB_WAIT;
            ARB_WAIT:  if (mst_done_i || w_timeout) w_next = ARB_RESP;
            ARB_RESP:  w_next = ARB_IDLE;
            default:   w_next = ARB_IDLE;
        endcase
    end

    // Outputs decoded from state and the latched owner/command/response.
    always_comb begin
        newd_o      = (r_state == ARB_ISSUE);
        gnt_o       = (r_state != ARB_IDLE) ? req_onehot(r_owner) : '0;
        ack_o       = (r_state == ARB_RESP) ? req_onehot(r_owner) : '0;
        rdata_o     = r_rdata;
        err_o       = r_err;
        wr_o        = r_cmd.wr;
        slv_addr_o  = r_cmd.slv_addr;
        addr_o      = r_cmd.addr;
        wdata_o     = r_cmd.wdata;
        dbg_state_o = r_state;
    end

    // Latch owner and command at grant.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_owner <= 1'b0;
            r_cmd   <= '0;
        end else if (w_grant) begin
            r_owner <= w_winner;
            r_cmd   <= w_sel_cmd;
        end
    end

    // Wait-cycle counter, cleared on the response cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cnt <= '0;
        end else if (r_state == ARB_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == ARB_RESP) begin
            r_cnt <= '0;
        end
    end

    // Response capture: writes return zero data; a timeout reports error with zero data.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ARB_WAIT) begin
            if (mst_done_i) begin
                r_rdata <= r_cmd.wr ? '0 : mst_rdata_i;
                r_err   <= mst_slverr_i;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

endmodule
